// File: rtl/nabp_pkg.sv
// Shared types and size helpers for the NABP image writeback stage.
package nabp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KICK   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter width for n states; never narrower than one bit.
  function automatic int log2_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int pixel_total(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/nabp_sync_fifo.sv
// Single-clock FIFO with occupancy count; one instance buffers one PE output channel.
module nabp_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_C);
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; pointers guard validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nabp_image_writer.sv
// Image writeback: NUM_CH buffered PE channels merged into one raster-ordered pixel stream.
// Optional clamp/clip counting is enabled with NABP_IMAGE_WRITER_CLIP_EN.
module nabp_image_writer
  import nabp_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int PE_W       = 16,
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = log2_width(pixel_total(IMG_W, IMG_H))
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   hs_kick,
  input  logic [NUM_CH-1:0]      pe_valid,
  input  logic [NUM_CH*PE_W-1:0] pe_val,
  output logic [NUM_CH-1:0]      pe_ready,
  input  logic                   ir_enable,
  output logic                   ir_kick,
  output logic                   ir_done,
  output logic                   ir_addr_valid,
  output logic [ADDR_W-1:0]      ir_addr,
  output logic [DATA_W-1:0]      ir_val,
  output logic                   busy
`ifdef NABP_IMAGE_WRITER_CLIP_EN
  ,
  output logic [15:0]            clip_count
`endif
);

  localparam int TOTAL = pixel_total(IMG_W, IMG_H);
  localparam int SEL_W = log2_width(NUM_CH);
  localparam int COL_W = log2_width(IMG_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W:0]   TOTAL_C   = (ADDR_W + 1)'(TOTAL);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TOTAL - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_CH - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  state_t state;
  state_t state_next;

  logic [SEL_W-1:0]  sel;
  logic [COL_W-1:0]  col;
  logic [ADDR_W:0]   issued;
  logic [PE_W-1:0]   fifo_dout  [NUM_CH];
  logic [CNT_W-1:0]  fifo_count [NUM_CH];
  logic              streaming;
  logic              clearing;
  logic              load_p0;
  logic              accept;
  logic              last_accept;
  logic [DATA_W-1:0] pixel_p0;

  assign streaming   = (state == STREAM);
  assign clearing    = (state == KICK);
  assign accept      = ir_addr_valid && ir_enable;
  assign last_accept = accept && (ir_addr == ADDR_LAST);
  assign load_p0     = streaming && (!ir_addr_valid || ir_enable) &&
                       (fifo_count[sel] != '0) && (issued < TOTAL_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    ir_kick    = 1'b0;
    ir_done    = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (hs_kick) state_next = KICK;
      KICK: begin
        ir_kick    = 1'b1;
        state_next = STREAM;
      end
      STREAM:  if (last_accept) state_next = DONE;
      DONE: begin
        ir_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---- stage 0: per-channel FIFOs (push side)
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign pe_ready[c] = streaming && (fifo_count[c] < DEPTH_C);

    nabp_sync_fifo #(
      .WIDTH (PE_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clearing),
      .push    (pe_valid[c] && pe_ready[c]),
      .din     (pe_val[PE_W*c +: PE_W]),
      .pop     (load_p0 && (sel == SEL_W'(c))),
      .dout    (fifo_dout[c]),
      .count   (fifo_count[c])
    );
  end

  // Channel select follows x % NUM_CH and restarts at every row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel    <= '0;
      col    <= '0;
      issued <= '0;
    end else if (clearing) begin
      sel    <= '0;
      col    <= '0;
      issued <= '0;
    end else if (load_p0) begin
      issued <= issued + (ADDR_W + 1)'(1);
      if (col == COL_LAST) begin
        col <= '0;
        sel <= '0;
      end else begin
        col <= col + COL_W'(1);
        sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
      end
    end
  end

`ifdef NABP_IMAGE_WRITER_CLIP_EN
  localparam logic signed [PE_W-1:0] PIX_MAX = PE_W'((1 << DATA_W) - 1);

  // Returns {clipped, pixel}: signed word saturated into [0, 2^DATA_W-1].
  function automatic logic [DATA_W:0] clamp_pixel(input logic signed [PE_W-1:0] w);
    if (w < 0)
      return {1'b1, {DATA_W{1'b0}}};
    else if (w > PIX_MAX)
      return {1'b1, {DATA_W{1'b1}}};
    else
      return {1'b0, w[DATA_W-1:0]};
  endfunction

  logic signed [PE_W-1:0] word_p0;
  logic [DATA_W:0]        clamp_p0;
  logic                   clip_p0;
  logic                   clip_p1;

  assign word_p0  = fifo_dout[sel];
  assign clamp_p0 = clamp_pixel(word_p0);
  assign pixel_p0 = clamp_p0[DATA_W-1:0];
  assign clip_p0  = clamp_p0[DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_p1    <= 1'b0;
      clip_count <= '0;
    end else if (clearing) begin
      clip_p1    <= 1'b0;
      clip_count <= '0;
    end else begin
      if (load_p0) clip_p1 <= clip_p0;
      if (accept && clip_p1 && (clip_count != 16'hFFFF))
        clip_count <= clip_count + 16'd1;
    end
  end
`else
  logic [PE_W-1:0] word_p0;
  logic            unused_word_hi;

  assign word_p0        = fifo_dout[sel];
  assign pixel_p0       = word_p0[DATA_W-1:0];
  assign unused_word_hi = ^word_p0[PE_W-1:DATA_W];
`endif

  // ---- stage 1: output register, held until the sink accepts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_addr_valid <= 1'b0;
      ir_addr       <= '0;
      ir_val        <= '0;
    end else if (clearing) begin
      ir_addr_valid <= 1'b0;
      ir_addr       <= '0;
      ir_val        <= '0;
    end else if (load_p0) begin
      ir_addr_valid <= 1'b1;
      ir_addr       <= issued[ADDR_W-1:0];
      ir_val        <= pixel_p0;
    end else if (accept) begin
      ir_addr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nabp_image_writer.sv
// Directed bench for nabp_image_writer on an 8x2 image with four channels.
module tb_nabp_image_writer;

  localparam int NUM_CH = 4, PE_W = 16, DATA_W = 8, IMG_W = 8, IMG_H = 2;
  localparam int FIFO_DEPTH = 4, ADDR_W = 4, NPIX = 16, WPC = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   hs_kick;
  logic [NUM_CH-1:0]      pe_valid;
  logic [NUM_CH*PE_W-1:0] pe_val;
  logic [NUM_CH-1:0]      pe_ready;
  logic                   ir_enable;
  logic                   ir_kick;
  logic                   ir_done;
  logic                   ir_addr_valid;
  logic [ADDR_W-1:0]      ir_addr;
  logic [DATA_W-1:0]      ir_val;
  logic                   busy;
`ifdef NABP_IMAGE_WRITER_CLIP_EN
  logic [15:0]            clip_count;
`endif

  nabp_image_writer #(
    .NUM_CH(NUM_CH), .PE_W(PE_W), .DATA_W(DATA_W), .IMG_W(IMG_W),
    .IMG_H(IMG_H), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hs_kick(hs_kick), .pe_valid(pe_valid),
    .pe_val(pe_val), .pe_ready(pe_ready), .ir_enable(ir_enable),
    .ir_kick(ir_kick), .ir_done(ir_done), .ir_addr_valid(ir_addr_valid),
    .ir_addr(ir_addr), .ir_val(ir_val), .busy(busy)
`ifdef NABP_IMAGE_WRITER_CLIP_EN
    , .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // producer / sink drive state
  bit                prod_on = 1'b0;
  int                en_mode = 0;
  int                en_phase = 0;
  int                frame_cyc = 0;
  int                ch_delay [NUM_CH];
  int                kidx [NUM_CH];
  logic [15:0]       word_tab [NPIX];
  logic [7:0]        exp_val [NPIX];
  logic [NUM_CH-1:0] fire_q = '0;

  // sink records
  int                nbeat, kick_cnt, done_cnt, stab_err, stall_cnt, cyc = 0;
  logic [ADDR_W-1:0] got_addr [NPIX];
  logic [DATA_W-1:0] got_val [NPIX];
  int                beat_cyc [NPIX];
  bit                prev_hold = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_val;

  always @(posedge clk) fire_q <= pe_valid & pe_ready;

  // Channel c offers word k = word_tab[4k+c] once its delay has elapsed.
  initial begin
    forever begin
      @(negedge clk);
      if (!prod_on) begin
        frame_cyc = 0;
        pe_valid  = '0;
        for (int c = 0; c < NUM_CH; c++) kidx[c] = 0;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (fire_q[c]) kidx[c]++;
          pe_valid[c] = (kidx[c] < WPC) && (frame_cyc >= ch_delay[c]);
          pe_val[PE_W*c +: PE_W] = word_tab[((kidx[c] < WPC) ? kidx[c] : 0) * NUM_CH + c];
        end
        frame_cyc++;
      end
      en_phase++;
      ir_enable = (en_mode == 0) ? 1'b1 : ((en_phase % 2) == 0);
    end
  end

  // Records accepted beats, pulses and stability of held beats.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!reset_n) begin
        prev_hold = 1'b0;
      end else begin
        if (ir_kick) kick_cnt++;
        if (ir_done) done_cnt++;
        if (prev_hold && (!ir_addr_valid || ir_addr !== prev_addr || ir_val !== prev_val))
          stab_err++;
        if (ir_addr_valid && !ir_enable) stall_cnt++;
        prev_hold = ir_addr_valid && !ir_enable;
        prev_addr = ir_addr;
        prev_val  = ir_val;
        if (ir_addr_valid && ir_enable) begin
          if (nbeat < NPIX) begin
            got_addr[nbeat] = ir_addr;
            got_val[nbeat]  = ir_val;
            beat_cyc[nbeat] = cyc;
          end
          nbeat++;
        end
      end
    end
  end

  task automatic default_tables();
    for (int i = 0; i < NPIX; i++) begin
      word_tab[i] = 16'(i);
      exp_val[i]  = 8'(i);
    end
    for (int c = 0; c < NUM_CH; c++) ch_delay[c] = 0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    nbeat = 0; kick_cnt = 0; done_cnt = 0; stab_err = 0; stall_cnt = 0;
    prod_on = 1'b1;
    hs_kick = 1'b1;
    @(negedge clk);
    hs_kick = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic end_frame();
    prod_on = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; hs_kick = 1'b0; pe_valid = '0; pe_val = '0; ir_enable = 1'b0;
    default_tables();
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (ir_addr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ir_addr_valid); else passed++;
    total++; if ({ir_kick, ir_done} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {ir_kick, ir_done}); else passed++;
    total++; if (ir_addr !== '0 || ir_val !== '0) $display("FAIL reset_addr_val got %h/%h want 0/0", ir_addr, ir_val); else passed++;
    total++; if (pe_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", pe_ready); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stream();
    bit ok;
    default_tables();
    en_mode = 0;
    start_frame();
    wait_done(ok);
    #1;
    total++; if (!ok) $display("FAIL stream_timeout got no ir_done want ir_done"); else passed++;
    total++; if (kick_cnt !== 1) $display("FAIL stream_kick_cycles got %0d want 1", kick_cnt); else passed++;
    total++; if (nbeat !== NPIX) $display("FAIL stream_beats got %0d want %0d", nbeat, NPIX); else passed++;
    for (int i = 0; i < NPIX; i++) begin
      total++; if (got_addr[i] !== 4'(i)) $display("FAIL stream_addr[%0d] got %0d want %0d", i, got_addr[i], i); else passed++;
      total++; if (got_val[i] !== exp_val[i]) $display("FAIL stream_val[%0d] got %h want %h", i, got_val[i], exp_val[i]); else passed++;
    end
    total++; if (beat_cyc[NPIX-1] - beat_cyc[0] !== NPIX - 1) $display("FAIL stream_throughput got %0d want %0d", beat_cyc[NPIX-1] - beat_cyc[0], NPIX - 1); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL stream_busy_after got %b want 0", busy); else passed++;
    end_frame();
    total++; if (done_cnt !== 1) $display("FAIL stream_done_cycles got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    default_tables();
    en_mode = 1;
    start_frame();
    wait_done(ok);
    total++; if (!ok) $display("FAIL bp_timeout got no ir_done want ir_done"); else passed++;
    total++; if (nbeat !== NPIX) $display("FAIL bp_beats got %0d want %0d", nbeat, NPIX); else passed++;
    for (int i = 0; i < NPIX; i++) begin
      total++; if (got_addr[i] !== 4'(i) || got_val[i] !== exp_val[i])
        $display("FAIL bp_beat[%0d] got %0d/%h want %0d/%h", i, got_addr[i], got_val[i], i, exp_val[i]); else passed++;
    end
    total++; if (stab_err !== 0) $display("FAIL bp_stable got %0d changes want 0", stab_err); else passed++;
    total++; if (stall_cnt == 0) $display("FAIL bp_stalled got %0d held cycles want >0", stall_cnt); else passed++;
    end_frame();
    en_mode = 0;
    total++; if (done_cnt !== 1) $display("FAIL bp_done got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_stall();
    bit ok;
    default_tables();
    ch_delay[2] = 10;
    start_frame();
    repeat (8) @(negedge clk);
    #2;
    // Beats 0,1 drained; ch3 holds all 4 words (full); ch2 still waiting.
    total++; if (nbeat !== 2) $display("FAIL stall_beats got %0d want 2", nbeat); else passed++;
    total++; if (ir_addr_valid !== 1'b0) $display("FAIL stall_valid got %b want 0", ir_addr_valid); else passed++;
    total++; if (pe_ready[3] !== 1'b0) $display("FAIL stall_full_ready got %b want 0", pe_ready[3]); else passed++;
    total++; if (pe_ready[2] !== 1'b1) $display("FAIL stall_empty_ready got %b want 1", pe_ready[2]); else passed++;
    wait_done(ok);
    total++; if (!ok) $display("FAIL stall_timeout got no ir_done want ir_done"); else passed++;
    total++; if (nbeat !== NPIX) $display("FAIL stall_total got %0d want %0d", nbeat, NPIX); else passed++;
    for (int i = 0; i < NPIX; i++) begin
      total++; if (got_addr[i] !== 4'(i) || got_val[i] !== exp_val[i])
        $display("FAIL stall_beat[%0d] got %0d/%h want %0d/%h", i, got_addr[i], got_val[i], i, exp_val[i]); else passed++;
    end
    end_frame();
    ch_delay[2] = 0;
  endtask

  task automatic test_kick_ignored();
    bit ok;
    bit found = 1'b0;
    default_tables();
    start_frame();
    repeat (100) begin
      @(negedge clk);
      if (ir_addr_valid && ir_addr == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    hs_kick = 1'b1;
    @(negedge clk);
    hs_kick = 1'b0;
    total++; if (!found) $display("FAIL kick_reach5 got no addr 5 want addr 5"); else passed++;
    wait_done(ok);
    total++; if (!ok) $display("FAIL kick_timeout got no ir_done want ir_done"); else passed++;
    total++; if (nbeat !== NPIX) $display("FAIL kick_beats got %0d want %0d", nbeat, NPIX); else passed++;
    for (int i = 0; i < NPIX; i++) begin
      total++; if (got_addr[i] !== 4'(i)) $display("FAIL kick_addr[%0d] got %0d want %0d", i, got_addr[i], i); else passed++;
    end
    end_frame();
    #1;
    total++; if (kick_cnt !== 1 || done_cnt !== 1) $display("FAIL kick_pulses got %0d/%0d want 1/1", kick_cnt, done_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL kick_busy_after got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bit found = 1'b0;
    default_tables();
    start_frame();
    repeat (100) begin
      @(negedge clk);
      if (ir_addr_valid && ir_addr == 4'd9) begin
        found = 1'b1;
        break;
      end
    end
    reset_n = 1'b0;
    prod_on = 1'b0;
    #1;
    total++; if (!found) $display("FAIL rst_reach9 got no addr 9 want addr 9"); else passed++;
    total++; if ({ir_addr_valid, busy, ir_kick, ir_done} !== 4'b0000)
      $display("FAIL rst_ctrl got %b want 0000", {ir_addr_valid, busy, ir_kick, ir_done}); else passed++;
    total++; if (ir_addr !== '0 || ir_val !== '0) $display("FAIL rst_data got %h/%h want 0/0", ir_addr, ir_val); else passed++;
    total++; if (pe_ready !== 4'b0000) $display("FAIL rst_ready got %b want 0000", pe_ready); else passed++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (done_cnt !== 0) $display("FAIL rst_no_done got %0d want 0", done_cnt); else passed++;
    start_frame();
    wait_done(ok);
    total++; if (!ok) $display("FAIL rst_restart_timeout got no ir_done want ir_done"); else passed++;
    total++; if (nbeat !== NPIX) $display("FAIL rst_restart_beats got %0d want %0d", nbeat, NPIX); else passed++;
    for (int i = 0; i < NPIX; i++) begin
      total++; if (got_addr[i] !== 4'(i) || got_val[i] !== exp_val[i])
        $display("FAIL rst_beat[%0d] got %0d/%h want %0d/%h", i, got_addr[i], got_val[i], i, exp_val[i]); else passed++;
    end
    end_frame();
  endtask

  task automatic test_clip();
    bit ok;
    default_tables();
    word_tab[0] = 16'hFFF0;
    word_tab[1] = 16'h0100;
    word_tab[2] = 16'h0042;
`ifdef NABP_IMAGE_WRITER_CLIP_EN
    exp_val[0] = 8'h00; exp_val[1] = 8'hFF; exp_val[2] = 8'h42;
`else
    exp_val[0] = 8'hF0; exp_val[1] = 8'h00; exp_val[2] = 8'h42;
`endif
    start_frame();
    wait_done(ok);
    total++; if (!ok) $display("FAIL clip_timeout got no ir_done want ir_done"); else passed++;
    for (int i = 0; i < NPIX; i++) begin
      total++; if (got_val[i] !== exp_val[i]) $display("FAIL clip_val[%0d] got %h want %h", i, got_val[i], exp_val[i]); else passed++;
    end
`ifdef NABP_IMAGE_WRITER_CLIP_EN
    total++; if (clip_count !== 16'd2) $display("FAIL clip_count got %0d want 2", clip_count); else passed++;
`endif
    end_frame();
    default_tables();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_kick_ignored();
    test_reset_midframe();
    test_clip();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
